// File: rtl/hud_pkg.sv
// Shared HUD definitions: BCD geometry, the blank-cell code and the
// scheduler FSM state type.
package hud_pkg;

    localparam int BIN_W      = 9;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int CNT_W      = 4;

    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
    localparam logic [CNT_W-1:0]   SHIFT_LAST  = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping modulo NUM_CH. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  pointer,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  index
);

    // Scan channels starting at the pointer and take the first hit.
    always_comb begin
        logic found;
        int   c;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(pointer) + i) % NUM_CH;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                index    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Shares one serial double-dabble engine between NUM_CH binary requesters
// and keeps a 3-digit BCD result per channel for the glyph renderer.
// Optional: define SCORE_LEADING_ZERO_BLANK_EN to store leading zeros of
// the hundreds/tens digits as BLANK_DIGIT.
module score_bcd_scheduler
    import hud_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 req,
    input  logic [NUM_CH*BIN_W-1:0]           value,
    output logic [NUM_CH-1:0]                 ack,
    output logic [NUM_CH*DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_CH-1:0]                 digits_valid,
    output logic                              busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RES_W = DIGIT_W * NUM_DIGITS;

    state_t               state, state_n;
    logic [BIN_W-1:0]     shift_q;
    logic [DIGIT_W-1:0]   hun_q, ten_q, one_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     ptr_q, ch_q;
    logic [NUM_CH-1:0]    grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 start;
    logic [DIGIT_W-1:0]   hun_adj, ten_adj, one_adj;
    logic [RES_W+BIN_W-1:0] chain_sh;
    logic [RES_W-1:0]     write_word;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req     (req),
        .pointer (ptr_q),
        .grant   (grant),
        .index   (grant_idx)
    );

    // A job starts only from IDLE; reset also blocks the combinational ack.
    assign start = (state == IDLE) && (|req) && !reset;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state decode plus ack/busy outputs.
    always_comb begin
        state_n = state;
        ack     = '0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ack     = grant;
                    busy    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == '0) state_n = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to any nibble >= 5, then shift the chain left.
    always_comb begin
        hun_adj  = (hun_q >= 4'd5) ? hun_q + 4'd3 : hun_q;
        ten_adj  = (ten_q >= 4'd5) ? ten_q + 4'd3 : ten_q;
        one_adj  = (one_q >= 4'd5) ? one_q + 4'd3 : one_q;
        chain_sh = {hun_adj[DIGIT_W-2:0], ten_adj, one_adj, shift_q, 1'b0};
    end

    // Result formatting, optionally blanking leading zeros.
    always_comb begin
        write_word = {hun_q, ten_q, one_q};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (hun_q == '0) begin
            write_word[RES_W-1 -: DIGIT_W] = BLANK_DIGIT;
            if (ten_q == '0) write_word[2*DIGIT_W-1 -: DIGIT_W] = BLANK_DIGIT;
        end
`endif
    end

    // Work registers, round-robin pointer and per-channel result storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the result registers are reset too, since the renderer must read zeros until first write.
            shift_q      <= '0;
            hun_q        <= '0;
            ten_q        <= '0;
            one_q        <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            ch_q         <= '0;
            digits       <= '0;
            digits_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= value[grant_idx*BIN_W +: BIN_W];
                        hun_q   <= '0;
                        ten_q   <= '0;
                        one_q   <= '0;
                        cnt_q   <= SHIFT_LAST;
                        ch_q    <= grant_idx;
                        ptr_q   <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                SHIFT: begin
                    {hun_q, ten_q, one_q, shift_q} <= chain_sh;
                    cnt_q <= cnt_q - 1'b1;
                end
                WRITE: begin
                    digits[ch_q*RES_W +: RES_W] <= write_word;
                    digits_valid[ch_q]          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Self-checking bench for score_bcd_scheduler with a cycle-level
// behavioural reference model (arithmetic BCD, integer round-robin).
module tb_score_bcd_scheduler;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*9-1:0]   value = '0;
    logic [N-1:0]     ack;
    logic [N*12-1:0]  digits;
    logic [N-1:0]     digits_valid;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    int           m_ptr;
    int           m_left;
    int           m_ch;
    logic [8:0]   m_val;
    logic [11:0]  m_dig [N];
    logic [N-1:0] m_valid;
    logic [N-1:0] hold_mask = '0;
    logic [N-1:0] drop_pending = '0;

    score_bcd_scheduler #(.NUM_CH(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .value        (value),
        .ack          (ack),
        .digits       (digits),
        .digits_valid (digits_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        if (h == 0) begin
            if (t == 0) t = 15;
            h = 15;
        end
`endif
        return {4'(h), 4'(t), 4'(o)};
    endfunction

    function automatic logic [N*12-1:0] model_digits();
        logic [N*12-1:0] d;
        for (int i = 0; i < N; i++) d[i*12 +: 12] = m_dig[i];
        return d;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_left  = 0;
        m_ch    = 0;
        m_val   = '0;
        m_valid = '0;
        for (int i = 0; i < N; i++) m_dig[i] = '0;
        drop_pending = '0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model,
    // then release acknowledged requests just after the next rising edge.
    task automatic cycle();
        logic [N-1:0] e_ack;
        logic         e_busy;
        logic         wr;
        int           g;
        @(negedge clk);
        e_ack = '0;
        e_busy = 1'b0;
        wr = 1'b0;
        if (m_left == 0) begin
            if (req != '0) begin
                g = -1;
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (m_ptr + i) % N;
                    if (g < 0 && req[c]) g = c;
                end
                e_ack[g] = 1'b1;
                e_busy   = 1'b1;
                m_ch     = g;
                m_val    = value[g*9 +: 9];
                m_ptr    = (g + 1) % N;
                m_left   = 10;
                if (!hold_mask[g]) drop_pending[g] = 1'b1;
            end
        end else begin
            e_busy = 1'b1;
            if (m_left == 1) wr = 1'b1;
            m_left--;
        end
        total++;
        if (ack !== e_ack) begin
            bad++;
            $display("FAIL ack cycle=%0d got=%b exp=%b", cyc, ack, e_ack);
        end
        total++;
        if (busy !== e_busy) begin
            bad++;
            $display("FAIL busy cycle=%0d got=%b exp=%b", cyc, busy, e_busy);
        end
        total++;
        if (digits !== model_digits()) begin
            bad++;
            $display("FAIL digits cycle=%0d got=%h exp=%h", cyc, digits, model_digits());
        end
        total++;
        if (digits_valid !== m_valid) begin
            bad++;
            $display("FAIL digits_valid cycle=%0d got=%b exp=%b", cyc, digits_valid, m_valid);
        end
        if (wr) begin
            m_dig[m_ch]   = ref_bcd(int'(m_val));
            m_valid[m_ch] = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
        req = req & ~drop_pending;
        drop_pending = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_zero_outputs(input string name);
        total++;
        if (ack !== '0 || busy !== 1'b0 || digits !== '0 || digits_valid !== '0) begin
            bad++;
            $display("FAIL %s got ack=%b busy=%b digits=%h valid=%b exp all zero",
                     name, ack, busy, digits, digits_valid);
        end
    endtask

    task automatic do_reset();
        req = '0;
        hold_mask = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 3'b111;
        value = {9'd1, 9'd2, 9'd3};
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        value = {9'd0, 9'd0, 9'd255};
        req = 3'b001;
        run(13);
        total++;
        if (digits[11:0] !== 12'h255 || digits_valid !== 3'b001) begin
            bad++;
            $display("FAIL single_255 got=%h valid=%b exp=255 valid=001", digits[11:0], digits_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [N*12-1:0] exp;
        do_reset();
        value = {9'd511, 9'd99, 9'd0};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        exp = {12'h511, 12'hF99, 12'hFF0};
`else
        exp = {12'h511, 12'h099, 12'h000};
`endif
        req = 3'b111;
        run(36);
        total++;
        if (digits !== exp || digits_valid !== 3'b111) begin
            bad++;
            $display("FAIL simultaneous got=%h exp=%h valid=%b", digits, exp, digits_valid);
        end
    endtask

    task automatic test_blank();
        logic [N*12-1:0] exp;
        do_reset();
        value = {9'd0, 9'd40, 9'd7};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        exp = {12'hFF0, 12'hF40, 12'hFF7};
`else
        exp = {12'h000, 12'h040, 12'h007};
`endif
        req = 3'b111;
        run(36);
        total++;
        if (digits !== exp) begin
            bad++;
            $display("FAIL blank_format got=%h exp=%h", digits, exp);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        value = {9'($urandom_range(511)), 9'd0, 9'($urandom_range(511))};
        hold_mask = 3'b101;
        req = 3'b101;
        run(50);
        hold_mask = '0;
        req = '0;
        run(12);
        total++;
        if (digits_valid !== 3'b101) begin
            bad++;
            $display("FAIL alternate_valid got=%b exp=101", digits_valid);
        end
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        value = {9'd0, 9'd300, 9'd0};
        req = 3'b010;
        run(5);
        value = {9'd0, 9'd300, 9'd123};
        req = 3'b001;
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("reset_mid_job");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run(15);
        total++;
        if (digits_valid !== 3'b001) begin
            bad++;
            $display("FAIL reset_no_write got valid=%b exp=001", digits_valid);
        end
    endtask

    task automatic test_drop();
        do_reset();
        value = {9'd0, 9'd77, 9'($urandom_range(511))};
        req = 3'b001;
        run(2);
        req = req | 3'b010;
        run(8);
        req = req & 3'b101;
        run(12);
        total++;
        if (digits_valid[1] !== 1'b0 || digits[23:12] !== 12'h000) begin
            bad++;
            $display("FAIL dropped_req got valid1=%b dig1=%h exp 0/000", digits_valid[1], digits[23:12]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4) == 0) begin
                    value[i*9 +: 9] = 9'($urandom_range(511));
                    req[i] = 1'b1;
                end else if (req[i] && ($urandom % 20) == 0) begin
                    req[i] = 1'b0;
                end
            end
            cycle();
        end
        req = '0;
        run(12);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_blank();
        test_alternate();
        test_reset_mid_job();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
